writeback_queue: RTL and testbench
==================================

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

Interface
REQ-001 Parameter DES, default 4, destination register index width.
REQ-002 Parameter REGISTER_WIDTH, default 32, result data width.
REQ-003 Parameter BRANCH_ID, default 3, branch tag width.
REQ-004 Parameter DEPTH, default 8, number of queue entries; SHALL be a power of two and at least 4.
REQ-005 clk  input  1  clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 res_k_vld  input  1  result valid on lane k (k=1..4); lane 1 is oldest in program order.
REQ-008 res_k_des  input  DES  destination register of lane k.
REQ-009 res_k_data  input  REGISTER_WIDTH  result data of lane k.
REQ-010 res_k_bid  input  BRANCH_ID  branch tag of lane k.
REQ-011 res_rdy  output  1  queue can accept all four lanes this cycle.
REQ-012 flush_vld  input  1  misprediction flush request.
REQ-013 flush_bid  input  BRANCH_ID  branch tag to kill.
REQ-014 back_k_vld  output  1  register-file write enable, port k (k=1..4).
REQ-015 back_k_des  output  DES  register-file write index, port k.
REQ-016 back_k_data  output  REGISTER_WIDTH  register-file write data, port k.
REQ-017 count  output  clog2(DEPTH+1)  current number of occupied entries.

Function
REQ-018 res_rdy SHALL be combinational from count: high when DEPTH-count >= 4.
REQ-019 A lane SHALL be enqueued when res_k_vld=1, res_rdy=1, res_k_des!=0, and not (flush active with res_k_bid=flush_bid); other lanes are dropped.
REQ-020 Enqueued lanes SHALL be compacted in lane order at the tail; tail advances by the number enqueued, modulo DEPTH.
REQ-021 Each cycle the drain SHALL select n (0..4) leading entries from the head: stop at the 4th entry, at the end of occupied entries, or before the first live entry whose des equals a live entry already selected this cycle.
REQ-022 Selected entry i SHALL be registered to back_i with back_i_vld=1 if live, 0 if killed; ports n+1..4 SHALL register back_vld=0; des/data SHALL be registered regardless of live status.
REQ-023 Head SHALL advance by n modulo DEPTH; count SHALL update as count+enq-n in the same edge.
REQ-024 Latency: a result accepted at edge t SHALL appear on back ports no earlier than the output of edge t+1 (one full cycle in queue).
REQ-025 Simultaneous enqueue and drain in one cycle SHALL be supported, including on a full or empty queue.
REQ-026 Wrap-around of head and tail pointers SHALL be transparent; ordering across the wrap SHALL be preserved.
REQ-027 Empty queue: n=0, all back_k_vld=0.

Reset
REQ-028 On rst: head=0, tail=0, count=0, all kill bits cleared, all back_k_vld/des/data=0, taking effect immediately without clk.
REQ-029 Reset mid-operation SHALL discard all entries; no write-back issues until new results are enqueued after reset deasserts.

Configuration
REQ-030 Macro WRITEBACK_QUEUE_FLUSH_EN defined: each entry holds a kill bit; flush_vld=1 SHALL set the kill bit of every occupied entry with matching bid at that edge; drain selection that cycle SHALL treat matching entries as killed (back_vld=0); killed entries are excluded from duplicate-des checking.
REQ-031 Macro not defined: flush_vld and flush_bid ports remain but are ignored; no kill bits are implemented; all entries are live; the REQ-019 flush filter is absent.

Structure
REQ-032 Package wbq_pkg SHALL hold the entry struct typedef (live/kill, des, bid, data) and the default width constants.
REQ-033 Drain selection (REQ-021) SHALL be a combinational sub-module wbq_drain_sel; storage, pointers and output registers stay in writeback_queue.

Verification
REQ-034 Four results des=1,2,3,4 in one cycle on an empty queue -> next cycle back_1..4 vld=1 with des 1,2,3,4 and matching data; count returns to 0.
REQ-035 Two results in one cycle, both des=5, data A then B -> back_1 writes A in one cycle, back_1 writes B in the following cycle; reg5 ends with B.
REQ-036 Twelve results held for 3 cycles while entries share des=7 -> res_rdy drops when count>4; no entry lost; order preserved across pointer wrap.
REQ-037 Lane with des=0 plus lane with des=9 -> only des=9 is written back; count never exceeds 1.
REQ-038 (FLUSH_EN) Enqueue bid 2 and bid 3 results, then flush_bid=2 -> bid 2 entries drain with back_vld=0; bid 3 entries write normally.
REQ-039 rst asserted with 6 entries queued -> count=0 and all back_vld=0 immediately; no stale write-back after release.

Source files
------------

// File: rtl/writeback_queue_pkg.sv
// Shared constants, entry format and lane helper for the write-back queue.
// Optional flush support is selected with WRITEBACK_QUEUE_FLUSH_EN.
package wbq_pkg;

    localparam int WBQ_DES            = 4;
    localparam int WBQ_REGISTER_WIDTH = 32;
    localparam int WBQ_BRANCH_ID      = 3;
    localparam int WBQ_DEPTH          = 8;
    localparam int WBQ_LANES          = 4;

    typedef struct packed {
        logic                          kill;
        logic [WBQ_DES-1:0]            des;
        logic [WBQ_BRANCH_ID-1:0]      bid;
        logic [WBQ_REGISTER_WIDTH-1:0] data;
    } wbq_entry_t;

    // Number of set bits in mask below position lane; gives each accepted lane its compacted slot.
    function automatic logic [2:0] ones_below(input logic [3:0] mask, input int lane);
        logic [2:0] c;
        c = '0;
        for (int j = 0; j < WBQ_LANES; j++) begin
            if (j < lane && mask[j]) c = c + 3'd1;
        end
        return c;
    endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Result, flush and register-file write-back bundle of the write-back queue.
interface writeback_queue_if
    import wbq_pkg::*;
#(
    parameter int DES            = WBQ_DES,
    parameter int REGISTER_WIDTH = WBQ_REGISTER_WIDTH,
    parameter int BRANCH_ID      = WBQ_BRANCH_ID,
    parameter int DEPTH          = WBQ_DEPTH
) ();
    localparam int CW = $clog2(DEPTH + 1);

    logic                      res_1_vld, res_2_vld, res_3_vld, res_4_vld;
    logic [DES-1:0]            res_1_des, res_2_des, res_3_des, res_4_des;
    logic [REGISTER_WIDTH-1:0] res_1_data, res_2_data, res_3_data, res_4_data;
    logic [BRANCH_ID-1:0]      res_1_bid, res_2_bid, res_3_bid, res_4_bid;
    logic                      res_rdy;

    logic                      flush_vld;
    logic [BRANCH_ID-1:0]      flush_bid;

    logic                      back_1_vld, back_2_vld, back_3_vld, back_4_vld;
    logic [DES-1:0]            back_1_des, back_2_des, back_3_des, back_4_des;
    logic [REGISTER_WIDTH-1:0] back_1_data, back_2_data, back_3_data, back_4_data;
    logic [CW-1:0]             count;

    modport master (
        output res_1_vld, res_2_vld, res_3_vld, res_4_vld,
        output res_1_des, res_2_des, res_3_des, res_4_des,
        output res_1_data, res_2_data, res_3_data, res_4_data,
        output res_1_bid, res_2_bid, res_3_bid, res_4_bid,
        output flush_vld, flush_bid,
        input  res_rdy, count,
        input  back_1_vld, back_2_vld, back_3_vld, back_4_vld,
        input  back_1_des, back_2_des, back_3_des, back_4_des,
        input  back_1_data, back_2_data, back_3_data, back_4_data
    );

    modport slave (
        input  res_1_vld, res_2_vld, res_3_vld, res_4_vld,
        input  res_1_des, res_2_des, res_3_des, res_4_des,
        input  res_1_data, res_2_data, res_3_data, res_4_data,
        input  res_1_bid, res_2_bid, res_3_bid, res_4_bid,
        input  flush_vld, flush_bid,
        output res_rdy, count,
        output back_1_vld, back_2_vld, back_3_vld, back_4_vld,
        output back_1_des, back_2_des, back_3_des, back_4_des,
        output back_1_data, back_2_data, back_3_data, back_4_data
    );
endinterface

// File: rtl/writeback_queue_drain_sel.sv
// Picks how many leading queue entries may be written back together this cycle
// without two live writes to the same destination register.
module wbq_drain_sel
    import wbq_pkg::*;
#(
    parameter int DES   = WBQ_DES,
    parameter int DEPTH = WBQ_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic [CW-1:0]             count,
    input  logic [WBQ_LANES-1:0][DES-1:0] des,
    input  logic [WBQ_LANES-1:0]      live,
    output logic [2:0]                n
);
    logic stop;

    // NOTE: blocking assignments here are intentional: stop and n are evaluated
    // sequentially through the loop, and both get a default first so no latch is inferred.
    always_comb begin
        n    = '0;
        stop = 1'b0;
        for (int i = 0; i < WBQ_LANES; i++) begin
            if (!stop) begin
                if (CW'(i) >= count) begin
                    stop = 1'b1;
                end else begin
                    for (int j = 0; j < i; j++) begin
                        if (live[i] && live[j] && des[i] == des[j]) stop = 1'b1;
                    end
                    if (!stop) n = 3'(i + 1);
                end
            end
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// Four-lane result queue feeding four register-file write ports in program order.
// Define WRITEBACK_QUEUE_FLUSH_EN to enable branch-tag kill on misprediction flush.
module writeback_queue
    import wbq_pkg::*;
#(
    parameter int DES            = WBQ_DES,
    parameter int REGISTER_WIDTH = WBQ_REGISTER_WIDTH,
    parameter int BRANCH_ID      = WBQ_BRANCH_ID,
    parameter int DEPTH          = WBQ_DEPTH
) (
    input logic               clk,
    input logic               rst,
    writeback_queue_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("writeback_queue: DEPTH must be a power of two and at least 4");
    end

    logic [WBQ_LANES-1:0]                     in_vld;
    logic [WBQ_LANES-1:0][DES-1:0]            in_des;
    logic [WBQ_LANES-1:0][REGISTER_WIDTH-1:0] in_data;
    logic [WBQ_LANES-1:0][BRANCH_ID-1:0]      in_bid;

    assign in_vld  = {bus.res_4_vld, bus.res_3_vld, bus.res_2_vld, bus.res_1_vld};
    assign in_des  = {bus.res_4_des, bus.res_3_des, bus.res_2_des, bus.res_1_des};
    assign in_data = {bus.res_4_data, bus.res_3_data, bus.res_2_data, bus.res_1_data};
    assign in_bid  = {bus.res_4_bid, bus.res_3_bid, bus.res_2_bid, bus.res_1_bid};

    logic [DES-1:0]            des_mem  [DEPTH];
    logic [REGISTER_WIDTH-1:0] data_mem [DEPTH];
    logic [PW-1:0]             head_q, tail_q;
    logic [CW-1:0]             count_q;

    logic [WBQ_LANES-1:0]                     back_vld_q;
    logic [WBQ_LANES-1:0][DES-1:0]            back_des_q;
    logic [WBQ_LANES-1:0][REGISTER_WIDTH-1:0] back_data_q;

    logic                                     res_rdy;
    logic [WBQ_LANES-1:0]                     lane_killed, accept;
    logic [WBQ_LANES-1:0][PW-1:0]             wr_idx, rd_idx;
    logic [2:0]                               enq_cnt, sel_n;
    logic [WBQ_LANES-1:0][DES-1:0]            hd_des;
    logic [WBQ_LANES-1:0][REGISTER_WIDTH-1:0] hd_data;
    logic [WBQ_LANES-1:0]                     hd_live;

`ifdef WRITEBACK_QUEUE_FLUSH_EN
    logic [BRANCH_ID-1:0] bid_mem [DEPTH];
    logic [DEPTH-1:0]     kill_q;

    always_comb begin
        for (int k = 0; k < WBQ_LANES; k++) begin
            lane_killed[k] = bus.flush_vld && (in_bid[k] == bus.flush_bid);
        end
    end
`else
    logic unused_flush;
    assign unused_flush = ^{bus.flush_vld, bus.flush_bid, in_bid};
    assign lane_killed  = '0;
`endif

    assign res_rdy = (count_q <= CW'(DEPTH - 4));

    always_comb begin
        for (int k = 0; k < WBQ_LANES; k++) begin
            accept[k] = in_vld[k] && res_rdy && (in_des[k] != '0) && !lane_killed[k];
        end
        for (int k = 0; k < WBQ_LANES; k++) begin
            wr_idx[k] = tail_q + PW'(ones_below(accept, k));
        end
        enq_cnt = ones_below(accept, WBQ_LANES);
    end

    // The four entries at the head; entries hit by a flush this cycle already count as dead.
    always_comb begin
        for (int i = 0; i < WBQ_LANES; i++) begin
            rd_idx[i]  = head_q + PW'(i);
            hd_des[i]  = des_mem[rd_idx[i]];
            hd_data[i] = data_mem[rd_idx[i]];
`ifdef WRITEBACK_QUEUE_FLUSH_EN
            hd_live[i] = !(kill_q[rd_idx[i]] ||
                           (bus.flush_vld && bid_mem[rd_idx[i]] == bus.flush_bid));
`else
            hd_live[i] = 1'b1;
`endif
        end
    end

    wbq_drain_sel #(.DES(DES), .DEPTH(DEPTH), .CW(CW)) u_drain_sel (
        .count (count_q),
        .des   (hd_des),
        .live  (hd_live),
        .n     (sel_n)
    );

    // NOTE: the payload arrays carry no reset; occupancy is tracked by head/tail/count,
    // so stale contents are never observed and the arrays stay plain RAM.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WBQ_LANES; k++) begin
            if (accept[k]) begin
                des_mem[wr_idx[k]]  <= in_des[k];
                data_mem[wr_idx[k]] <= in_data[k];
`ifdef WRITEBACK_QUEUE_FLUSH_EN
                bid_mem[wr_idx[k]]  <= in_bid[k];
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            back_vld_q  <= '0;
            back_des_q  <= '0;
            back_data_q <= '0;
`ifdef WRITEBACK_QUEUE_FLUSH_EN
            kill_q      <= '0;
`endif
        end else begin
`ifdef WRITEBACK_QUEUE_FLUSH_EN
            // Newly written slots must clear their kill bit after the flush marking.
            if (bus.flush_vld) begin
                for (int e = 0; e < DEPTH; e++) begin
                    if (bid_mem[e] == bus.flush_bid) kill_q[e] <= 1'b1;
                end
            end
            for (int k = 0; k < WBQ_LANES; k++) begin
                if (accept[k]) kill_q[wr_idx[k]] <= 1'b0;
            end
`endif
            for (int i = 0; i < WBQ_LANES; i++) begin
                back_vld_q[i] <= (3'(i) < sel_n) && hd_live[i];
                if (3'(i) < sel_n) begin
                    back_des_q[i]  <= hd_des[i];
                    back_data_q[i] <= hd_data[i];
                end
            end
            head_q  <= head_q + PW'(sel_n);
            tail_q  <= tail_q + PW'(enq_cnt);
            count_q <= count_q + CW'(enq_cnt) - CW'(sel_n);
        end
    end

    assign bus.res_rdy     = res_rdy;
    assign bus.count       = count_q;
    assign bus.back_1_vld  = back_vld_q[0];
    assign bus.back_2_vld  = back_vld_q[1];
    assign bus.back_3_vld  = back_vld_q[2];
    assign bus.back_4_vld  = back_vld_q[3];
    assign bus.back_1_des  = back_des_q[0];
    assign bus.back_2_des  = back_des_q[1];
    assign bus.back_3_des  = back_des_q[2];
    assign bus.back_4_des  = back_des_q[3];
    assign bus.back_1_data = back_data_q[0];
    assign bus.back_2_data = back_data_q[1];
    assign bus.back_3_data = back_data_q[2];
    assign bus.back_4_data = back_data_q[3];
endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: single-cycle vector table plus multi-cycle sequences.
module tb_writeback_queue;
    import wbq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_queue_if bus ();
    writeback_queue dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    logic [3:0]        bv;
    logic [3:0][3:0]   bd;
    logic [3:0][31:0]  bdat;
    assign bv   = {bus.back_4_vld, bus.back_3_vld, bus.back_2_vld, bus.back_1_vld};
    assign bd   = {bus.back_4_des, bus.back_3_des, bus.back_2_des, bus.back_1_des};
    assign bdat = {bus.back_4_data, bus.back_3_data, bus.back_2_data, bus.back_1_data};

    task automatic set_lane(input int k, input logic v, input logic [3:0] d,
                            input logic [31:0] dat, input logic [2:0] b);
        case (k)
            0: begin bus.res_1_vld = v; bus.res_1_des = d; bus.res_1_data = dat; bus.res_1_bid = b; end
            1: begin bus.res_2_vld = v; bus.res_2_des = d; bus.res_2_data = dat; bus.res_2_bid = b; end
            2: begin bus.res_3_vld = v; bus.res_3_des = d; bus.res_3_data = dat; bus.res_3_bid = b; end
            default: begin bus.res_4_vld = v; bus.res_4_des = d; bus.res_4_data = dat; bus.res_4_bid = b; end
        endcase
    endtask

    task automatic clear_lanes();
        for (int k = 0; k < 4; k++) set_lane(k, 1'b0, 4'd0, 32'd0, 3'd0);
    endtask

    task automatic wait_empty(input string name);
        int g = 0;
        while (bus.count != 0 && g < 30) begin
            @(negedge clk);
            g++;
        end
        check(name, 64'(bus.count), 64'd0);
    endtask

    // Register-file model written from the back ports; a later port wins on equal index.
    logic [31:0] rf [16];
    always @(posedge clk) begin
        for (int p = 0; p < 4; p++) if (bv[p]) rf[bd[p]] <= bdat[p];
    end

    bit         mon_en = 0;
    bit         watch_en = 0;
    int         vld_seen = 0;
    wbq_entry_t got_q[$];
    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < 4; p++) begin
                if (bv[p]) got_q.push_back('{kill: 1'b0, des: bd[p], bid: 3'd0, data: bdat[p]});
            end
            check("rdy_vs_count", 64'(bus.res_rdy), 64'(bus.count <= 4'd4));
        end
        if (watch_en) vld_seen += $countones(bv);
    end

    typedef struct {
        logic [3:0]      vld;
        logic [3:0][3:0] des;
        logic [3:0][1:0] src;
        int              cnt1;
        logic [3:0]      mask;
        int              cnt2;
    } vec_t;

    function automatic vec_t mkvec(input logic [3:0] vld, input logic [3:0][3:0] des,
                                   input logic [3:0][1:0] src, input int cnt1,
                                   input logic [3:0] mask, input int cnt2);
        vec_t r;
        r.vld = vld; r.des = des; r.src = src; r.cnt1 = cnt1; r.mask = mask; r.cnt2 = cnt2;
        return r;
    endfunction

    function automatic logic [31:0] vdat(input int v, input int k);
        return 32'hC000_0000 | 32'(v << 8) | 32'(k);
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[7];
        wbq_entry_t exp_q[$];
        logic [3:0] pat36[3][4];
        bit         saw_block;
        int         g;

        rst = 1'b1;
        clear_lanes();
        bus.flush_vld = 1'b0;
        bus.flush_bid = 3'd0;
        #1;
        check("reset_count", 64'(bus.count), 64'd0);
        check("reset_vld", 64'(bv), 64'd0);
        check("reset_rdy", 64'(bus.res_rdy), 64'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Each vector starts on an empty queue: lanes for one cycle, then two snapshots.
        vecs[0] = mkvec(4'b1111, {4'd4, 4'd3, 4'd2, 4'd1}, {2'd3, 2'd2, 2'd1, 2'd0}, 4, 4'b1111, 0);
        vecs[1] = mkvec(4'b0011, {4'd0, 4'd0, 4'd9, 4'd0}, {2'd0, 2'd0, 2'd0, 2'd1}, 1, 4'b0001, 0);
        vecs[2] = mkvec(4'b0101, {4'd0, 4'd8, 4'd0, 4'd6}, {2'd0, 2'd0, 2'd2, 2'd0}, 2, 4'b0011, 0);
        vecs[3] = mkvec(4'b1111, {4'd7, 4'd3, 4'd5, 4'd3}, {2'd0, 2'd0, 2'd1, 2'd0}, 4, 4'b0011, 2);
        vecs[4] = mkvec(4'b0000, {4'd1, 4'd2, 4'd3, 4'd4}, {2'd0, 2'd0, 2'd0, 2'd0}, 0, 4'b0000, 0);
        vecs[5] = mkvec(4'b1111, {4'd2, 4'd2, 4'd2, 4'd2}, {2'd0, 2'd0, 2'd0, 2'd0}, 4, 4'b0001, 3);
        vecs[6] = mkvec(4'b1010, {4'd12, 4'd5, 4'd11, 4'd5}, {2'd0, 2'd0, 2'd3, 2'd1}, 2, 4'b0011, 0);

        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) set_lane(k, vecs[v].vld[k], vecs[v].des[k], vdat(v, k), 3'd0);
            @(negedge clk);
            clear_lanes();
            check($sformatf("v%0d_count_enq", v), 64'(bus.count), 64'(vecs[v].cnt1));
            check($sformatf("v%0d_no_early_vld", v), 64'(bv), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_back_vld", v), 64'(bv), 64'(vecs[v].mask));
            for (int p = 0; p < 4; p++) begin
                if (vecs[v].mask[p]) begin
                    check($sformatf("v%0d_des%0d", v, p + 1), 64'(bd[p]), 64'(vecs[v].des[vecs[v].src[p]]));
                    check($sformatf("v%0d_data%0d", v, p + 1), 64'(bdat[p]), 64'(vdat(v, 32'(vecs[v].src[p]))));
                end
            end
            check($sformatf("v%0d_count_drain", v), 64'(bus.count), 64'(vecs[v].cnt2));
            wait_empty($sformatf("v%0d_empty", v));
        end

        // Same destination twice in one cycle: the older value is written first.
        @(negedge clk);
        set_lane(0, 1'b1, 4'd5, 32'hAAAA_0005, 3'd0);
        set_lane(1, 1'b1, 4'd5, 32'hBBBB_0005, 3'd0);
        @(negedge clk);
        clear_lanes();
        check("dup5_count", 64'(bus.count), 64'd2);
        @(negedge clk);
        check("dup5_first_vld", 64'(bv), 64'b0001);
        check("dup5_first_des", 64'(bd[0]), 64'd5);
        check("dup5_first_data", 64'(bdat[0]), 64'hAAAA_0005);
        @(negedge clk);
        check("dup5_second_vld", 64'(bv), 64'b0001);
        check("dup5_second_data", 64'(bdat[0]), 64'hBBBB_0005);
        check("dup5_count_end", 64'(bus.count), 64'd0);
        @(negedge clk);
        check("dup5_reg5", 64'(rf[5]), 64'hBBBB_0005);

        // Twelve results in three batches, many sharing des 7, with backpressure and wrap.
        pat36[0] = '{4'd7, 4'd7, 4'd1, 4'd7};
        pat36[1] = '{4'd7, 4'd2, 4'd7, 4'd7};
        pat36[2] = '{4'd3, 4'd7, 4'd7, 4'd4};
        got_q.delete();
        saw_block = 0;
        mon_en = 1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                set_lane(k, 1'b1, pat36[b][k], 32'h3600 + 32'(b * 4 + k), 3'd0);
                exp_q.push_back('{kill: 1'b0, des: pat36[b][k], bid: 3'd0, data: 32'h3600 + 32'(b * 4 + k)});
            end
            g = 0;
            while (!bus.res_rdy && g < 20) begin
                saw_block = 1;
                @(negedge clk);
                g++;
            end
            check($sformatf("q36_accept_b%0d", b), 64'(bus.res_rdy), 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        clear_lanes();
        wait_empty("q36_empty");
        repeat (2) @(negedge clk);
        mon_en = 0;
        check("q36_backpressure_seen", 64'(saw_block), 64'd1);
        check("q36_writes", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("q36_order%0d", i), 64'({got_q[i].des, got_q[i].data}),
                  64'({exp_q[i].des, exp_q[i].data}));
        end

        // Misprediction flush of tag 2 while tag 2 and tag 3 results are queued.
        @(negedge clk);
        set_lane(0, 1'b1, 4'd10, 32'h3800, 3'd2);
        set_lane(1, 1'b1, 4'd11, 32'h3801, 3'd3);
        set_lane(2, 1'b1, 4'd12, 32'h3802, 3'd2);
        set_lane(3, 1'b1, 4'd10, 32'h3803, 3'd3);
        @(negedge clk);
        set_lane(0, 1'b1, 4'd13, 32'h3804, 3'd2);
        set_lane(1, 1'b1, 4'd14, 32'h3805, 3'd3);
        set_lane(2, 1'b0, 4'd0, 32'd0, 3'd0);
        set_lane(3, 1'b0, 4'd0, 32'd0, 3'd0);
        bus.flush_vld = 1'b1;
        bus.flush_bid = 3'd2;
        @(negedge clk);
        clear_lanes();
        bus.flush_vld = 1'b0;
`ifdef WRITEBACK_QUEUE_FLUSH_EN
        check("flush_vld", 64'(bv), 64'b1010);
        check("flush_killed_des1", 64'(bd[0]), 64'd10);
        check("flush_killed_des3", 64'(bd[2]), 64'd12);
        check("flush_live_data2", 64'(bdat[1]), 64'h3801);
        check("flush_live_data4", 64'(bdat[3]), 64'h3803);
        check("flush_count", 64'(bus.count), 64'd1);
        @(negedge clk);
        check("flush_after_vld", 64'(bv), 64'b0001);
        check("flush_after_des", 64'(bd[0]), 64'd14);
`else
        check("noflush_vld", 64'(bv), 64'b0111);
        check("noflush_des", 64'({bd[2], bd[1], bd[0]}), 64'({4'd12, 4'd11, 4'd10}));
        check("noflush_count", 64'(bus.count), 64'd3);
        @(negedge clk);
        check("noflush_after_vld", 64'(bv), 64'b0111);
        check("noflush_after_des", 64'({bd[2], bd[1], bd[0]}), 64'({4'd14, 4'd13, 4'd10}));
`endif
        wait_empty("flush_empty");

        // Asynchronous reset with six entries queued.
        @(negedge clk);
        for (int k = 0; k < 4; k++) set_lane(k, 1'b1, 4'd8, 32'h3900 + 32'(k), 3'd0);
        @(negedge clk);
        for (int k = 0; k < 3; k++) set_lane(k, 1'b1, 4'd8, 32'h3910 + 32'(k), 3'd0);
        set_lane(3, 1'b0, 4'd0, 32'd0, 3'd0);
        @(negedge clk);
        clear_lanes();
        check("rst_pre_count", 64'(bus.count), 64'd6);
        check("rst_pre_vld", 64'(bv), 64'b0001);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_count", 64'(bus.count), 64'd0);
        check("rst_mid_vld", 64'(bv), 64'd0);
        check("rst_mid_rdy", 64'(bus.res_rdy), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        vld_seen = 0;
        watch_en = 1;
        repeat (5) @(negedge clk);
        watch_en = 0;
        check("rst_no_stale", 64'(vld_seen), 64'd0);
        set_lane(0, 1'b1, 4'd9, 32'h3A00, 3'd0);
        @(negedge clk);
        clear_lanes();
        @(negedge clk);
        check("rst_post_vld", 64'(bv), 64'b0001);
        check("rst_post_des", 64'(bd[0]), 64'd9);
        check("rst_post_data", 64'(bdat[0]), 64'h3A00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
